branch_target_adder: RTL and testbench

//   Computes the branch target address by adding a sign-extended byte offset to the PC.

---
 rtl/branch_target_adder_if.sv | 24 ++
 rtl/branch_target_adder.sv | 52 +++++
 tb/tb_branch_target_adder.sv | 114 +++++++++++
 3 files changed

// File: rtl/branch_target_adder_if.sv
// Bus between the EX-stage branch-target adder and its consumers.
// The master drives the pc/offset request; the slave returns the registered target and flags.
interface branch_target_adder_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] offset;
    logic             out_valid;
    logic [WIDTH-1:0] branch_target;
    logic             overflow;
    logic             carry_out;
    logic             misaligned;

    modport master (
        output in_valid, pc, offset,
        input  out_valid, branch_target, overflow, carry_out, misaligned
    );

    modport slave (
        input  in_valid, pc, offset,
        output out_valid, branch_target, overflow, carry_out, misaligned
    );
endinterface

// File: rtl/branch_target_adder.sv
// Adds a sign-extended byte offset to the PC and registers the target.
// Also registers the signed overflow, unsigned carry and misalignment flags.
module branch_target_adder #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned OFFSET_SHIFT = 0,
    parameter int unsigned ALIGN_BITS   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    branch_target_adder_if.slave  bus
);
    localparam int unsigned SUM_W = WIDTH + 1;
    localparam int unsigned MSB   = WIDTH - 1;

    // Low-bit mask of the target; an all-zero mask when ALIGN_BITS is 0.
    localparam logic [SUM_W-1:0] ONE        = SUM_W'(1);
    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'((ONE << ALIGN_BITS) - ONE);

    logic [WIDTH-1:0] shifted_c;
    logic [SUM_W-1:0] sum_c;
    logic [WIDTH-1:0] target_c;
    logic             overflow_c;
    logic             misaligned_c;

    // Combinational add; bits shifted past the MSB are dropped by the truncating cast.
    always_comb begin
        shifted_c    = WIDTH'(bus.offset << OFFSET_SHIFT);
        sum_c        = {1'b0, bus.pc} + {1'b0, shifted_c};
        target_c     = sum_c[WIDTH-1:0];
        overflow_c   = (bus.pc[MSB] == shifted_c[MSB]) && (target_c[MSB] != bus.pc[MSB]);
        misaligned_c = |(target_c & ALIGN_MASK);
    end

    // Result registers load only on a valid request so idle inputs cannot disturb them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.out_valid     <= 1'b0;
            bus.branch_target <= '0;
            bus.overflow      <= 1'b0;
            bus.carry_out     <= 1'b0;
            bus.misaligned    <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.branch_target <= target_c;
                bus.overflow      <= overflow_c;
                bus.carry_out     <= sum_c[WIDTH];
                bus.misaligned    <= misaligned_c;
            end
        end
    end
endmodule

// File: tb/tb_branch_target_adder.sv
// Directed bench for branch_target_adder: reset, offsets of both signs, back-to-back, flags, hold.
module tb_branch_target_adder;
    localparam int unsigned WIDTH = 32;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    branch_target_adder_if #(.WIDTH(WIDTH)) bus ();

    branch_target_adder #(
        .WIDTH        (WIDTH),
        .OFFSET_SHIFT (0),
        .ALIGN_BITS   (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Drive on the falling edge, then sample just after the next rising edge.
    task automatic step(input logic v, input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] o);
        @(negedge clk);
        bus.in_valid = v;
        bus.pc       = p;
        bus.offset   = o;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_all(input string tag, input logic v, input logic [WIDTH-1:0] t,
                              input logic ovf, input logic cy, input logic mis);
        check({tag, ".valid"}, WIDTH'(bus.out_valid), WIDTH'(v));
        check({tag, ".target"}, bus.branch_target, t);
        check({tag, ".overflow"}, WIDTH'(bus.overflow), WIDTH'(ovf));
        check({tag, ".carry"}, WIDTH'(bus.carry_out), WIDTH'(cy));
        check({tag, ".misaligned"}, WIDTH'(bus.misaligned), WIDTH'(mis));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.in_valid = 1'b0;
        bus.pc       = '0;
        bus.offset   = '0;

        // Reset holds priority over a valid request
        step(1'b1, 32'h7FFF_FFFF, 32'h0000_0001);
        step(1'b1, 32'h7FFF_FFFF, 32'h0000_0001);
        expect_all("reset", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;

        step(1'b1, 32'h0000_0004, 32'h0000_0010);
        expect_all("pos_off", 1'b1, 32'h0000_0014, 1'b0, 1'b0, 1'b0);

        step(1'b1, 32'h0000_0010, 32'hFFFF_FFF0);
        expect_all("neg_off", 1'b1, 32'h0000_0000, 1'b0, 1'b1, 1'b0);

        step(1'b1, 32'h0000_0020, 32'h0000_0004);
        expect_all("b2b_0", 1'b1, 32'h0000_0024, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h0000_0000, 32'h0000_0000);
        expect_all("b2b_1", 1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0);

        step(1'b1, 32'h7FFF_FFFF, 32'h0000_0001);
        expect_all("ovf_pos", 1'b1, 32'h8000_0000, 1'b1, 1'b0, 1'b0);

        step(1'b1, 32'h8000_0000, 32'h8000_0000);
        expect_all("ovf_neg", 1'b1, 32'h0000_0000, 1'b1, 1'b1, 1'b0);

        step(1'b1, 32'h0000_0002, 32'h0000_0000);
        expect_all("mis_bit1", 1'b1, 32'h0000_0002, 1'b0, 1'b0, 1'b1);

        step(1'b1, 32'h0000_0001, 32'h0000_0000);
        expect_all("mis_bit0", 1'b1, 32'h0000_0001, 1'b0, 1'b0, 1'b1);

        // Idle with unknown operands must leave the held result untouched
        step(1'b0, 32'hxxxx_xxxx, 32'hxxxx_xxxx);
        expect_all("hold", 1'b0, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'hxxxx_xxxx, 32'hxxxx_xxxx);
        expect_all("hold2", 1'b0, 32'h0000_0001, 1'b0, 1'b0, 1'b1);

        step(1'b1, 32'h0000_1000, 32'hFFFF_FFFC);
        expect_all("neg_small", 1'b1, 32'h0000_0FFC, 1'b0, 1'b1, 1'b0);

        // Reset arriving with a pending request discards it
        @(negedge clk);
        rst_n = 1'b0;
        step(1'b1, 32'h0000_0008, 32'h0000_0008);
        expect_all("mid_reset", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 32'h0000_0008, 32'h0000_0008);
        expect_all("post_reset", 1'b1, 32'h0000_0010, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
